uart_controller: RTL and testbench

Request sequencer between the `uart` byte interface and the sensor bus. It does four things:
- Detects a completed address+command pair on `addressIn`/`commandIn`.
- Validates the pair and issues one read to the addressed sensor.
- Builds the 3-byte response (address, response code, value) and triggers `uart` TX.
- Frees the UART receive path via `clearUart`.

Optionally, it also schedules periodic re-reads (continuous monitoring) between PC requests.

---
 rtl/uart_controller.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_uart_controller.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_controller.sv
// ---------------------------------------------------------------------------
// uart_controller
//
// Request sequencer between the uart byte interface and the sensor bus.
// It waits for a received address/command pair to settle and latches it.
// It then frees the uart receive path and validates the request. For a
// valid request it issues one sensor read. Finally it loads a 3-byte
// response (address, response code, value) and pulses start_send.
//
// Optional feature macro: UART_CTRL_CONTINUOUS_EN
//   When defined, commands 0x03/0x04 arm a continuous-monitoring slot.
//   The armed slot is re-read every CONT_PERIOD cycles between PC requests.
//   Commands 0x05/0x06 clear the slot.
//   When undefined, cont_active is tied to 0. Commands 0x03/0x04 act as
//   single reads, and commands 0x05/0x06 are rejected as invalid (0xCF).
//
// Ports
//   baudClk       in   1  9600 Hz clock shared with uart
//   reset         in   1  asynchronous, active-high reset
//   addressIn     in   8  received sensor address
//   commandIn     in   8  received command, 0xFF = no request
//   clearUart     out  1  asks uart to restore commandIn to 0xFF
//   address_out   out  8  response byte 0
//   command_out   out  8  response byte 1 (response code)
//   value_out     out  8  response byte 2
//   start_send    out  1  one-cycle TX start pulse
//   sensor_req    out  1  one-cycle sensor read strobe
//   sensor_addr   out  8  target sensor, stable from sensor_req until done
//   sensor_done   in   1  one-cycle completion strobe
//   sensor_error  in   1  error flag, sampled with sensor_done
//   sensor_temp   in   8  temperature, sampled with sensor_done
//   sensor_humid  in   8  humidity, sampled with sensor_done
//   busy          out  1  high in every state other than IDLE
//   cont_active   out  1  a continuous slot is armed
// ---------------------------------------------------------------------------
module uart_controller #(
   parameter int NUM_SENSORS    = 32,
   parameter int SETTLE_CYCLES  = 10,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int TX_CYCLES      = 32,
   parameter int CONT_PERIOD    = 9600
) (
   input  logic       baudClk,
   input  logic       reset,
   input  logic [7:0] addressIn,
   input  logic [7:0] commandIn,
   output logic       clearUart,
   output logic [7:0] address_out,
   output logic [7:0] command_out,
   output logic [7:0] value_out,
   output logic       start_send,
   output logic       sensor_req,
   output logic [7:0] sensor_addr,
   input  logic       sensor_done,
   input  logic       sensor_error,
   input  logic [7:0] sensor_temp,
   input  logic [7:0] sensor_humid,
   output logic       busy,
   output logic       cont_active
);

   typedef enum logic [3:0] {
      S_IDLE, S_SETTLE, S_ACCEPT, S_VALIDATE, S_SENSOR_REQ,
      S_SENSOR_WAIT, S_LOAD_TX, S_SEND, S_TX_WAIT
   } state_t;

   localparam logic [7:0] NO_CMD     = 8'hFF;
   localparam logic [7:0] RSP_OK     = 8'h07;
   localparam logic [7:0] RSP_HUMID  = 8'h08;
   localparam logic [7:0] RSP_TEMP   = 8'h09;
   localparam logic [7:0] RSP_TOFF   = 8'h0A;
   localparam logic [7:0] RSP_HOFF   = 8'h0B;
   localparam logic [7:0] RSP_SERR   = 8'h1F;
   localparam logic [7:0] RSP_BADCMD = 8'hCF;
   localparam logic [7:0] RSP_BADADR = 8'hEF;

   // One shared cycle counter serves SETTLE, SENSOR_WAIT and TX_WAIT.
   localparam int CNT_MAX_A = (SETTLE_CYCLES > TX_CYCLES) ? SETTLE_CYCLES : TX_CYCLES;
   localparam int CNT_MAX   = (TIMEOUT_CYCLES > CNT_MAX_A) ? TIMEOUT_CYCLES : CNT_MAX_A;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);

   state_t             r_state;
   state_t             w_next_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [7:0]         r_addr;
   logic [7:0]         r_cmd;
   logic [7:0]         r_resp_code;
   logic [7:0]         r_resp_val;
   logic [7:0]         r_sensor_addr;
   logic [7:0]         r_address_out;
   logic [7:0]         r_command_out;
   logic [7:0]         r_value_out;

   logic               w_cmd_present;
   logic               w_cmd_invalid;
   logic               w_addr_invalid;
   logic               w_cont_off;
   logic               w_go_sensor;
   logic               w_to_expired;
   logic               w_period_due;
   logic               w_slot_humid;
   logic [7:0]         w_slot_addr;
   logic               w_clear;
   logic               w_start;
   logic               w_req;
   logic               w_busy;

   assign w_cmd_present  = (commandIn != NO_CMD);
   assign w_addr_invalid = (32'(r_addr) >= NUM_SENSORS);
   assign w_to_expired   = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign w_go_sensor    = !w_cmd_invalid && !w_addr_invalid && !w_cont_off;

`ifdef UART_CTRL_CONTINUOUS_EN
   localparam int PCNT_W = $clog2(CONT_PERIOD + 1);

   logic              r_slot_valid;
   logic              r_slot_humid;
   logic [7:0]        r_slot_addr;
   logic [PCNT_W-1:0] r_period_cnt;
   logic              w_arm;
   logic              w_disarm;
   logic              w_periodic_start;

   assign w_cmd_invalid    = (r_cmd > 8'h06);
   assign w_cont_off       = (r_cmd == 8'h05) || (r_cmd == 8'h06);
   assign w_period_due     = r_slot_valid && (r_period_cnt == PCNT_W'(CONT_PERIOD));
   assign w_slot_addr      = r_slot_addr;
   assign w_slot_humid     = r_slot_humid;
   assign w_arm            = (r_state == S_SENSOR_WAIT) && sensor_done && !sensor_error &&
                             ((r_cmd == 8'h03) || (r_cmd == 8'h04));
   assign w_disarm         = (r_state == S_VALIDATE) && !w_cmd_invalid && !w_addr_invalid &&
                             w_cont_off;
   assign w_periodic_start = (r_state == S_IDLE) && (w_next_state == S_SENSOR_REQ);
   assign cont_active      = r_slot_valid;

   always_ff @(posedge baudClk or posedge reset) begin
      if (reset) begin
         r_slot_valid <= 1'b0;
         r_slot_humid <= 1'b0;
         r_slot_addr  <= 8'h00;
         r_period_cnt <= '0;
      end else begin
         if (w_arm) begin
            r_slot_valid <= 1'b1;
            r_slot_humid <= (r_cmd == 8'h04);
            r_slot_addr  <= r_addr;
         end else if (w_disarm) begin
            r_slot_valid <= 1'b0;
         end

         // Period counter: restarts on arm/disarm and on each periodic read,
         // otherwise counts up to CONT_PERIOD and sticks there until served.
         if (w_arm || w_disarm || w_periodic_start)
            r_period_cnt <= '0;
         else if (r_slot_valid && (r_period_cnt != PCNT_W'(CONT_PERIOD)))
            r_period_cnt <= r_period_cnt + 1'b1;
      end
   end
`else
   // Continuous commands 0x05/0x06 are not supported and count as invalid.
   assign w_cmd_invalid = (r_cmd > 8'h04);
   assign w_cont_off    = 1'b0;
   assign w_period_due  = 1'b0;
   assign w_slot_addr   = 8'h00;
   assign w_slot_humid  = 1'b0;
   assign cont_active   = 1'b0;
`endif

   // State register.
   always_ff @(posedge baudClk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         // Counter restarts on every state change, so each timed state
         // sees 0 in its first cycle.
         r_cnt   <= (w_next_state != r_state) ? '0 : r_cnt + 1'b1;
      end
   end

   // Next-state logic.
   always_comb begin
      // NOTE: default first, so no path through the case infers a latch.
      w_next_state = r_state;
      unique case (r_state)
         S_IDLE: begin
            // A PC request wins over an expired period; the period stays pending.
            if (w_cmd_present)     w_next_state = S_SETTLE;
            else if (w_period_due) w_next_state = S_SENSOR_REQ;
         end
         S_SETTLE: begin
            // commandIn fills bit by bit, so wait for it to hold steady.
            if (!w_cmd_present)                               w_next_state = S_IDLE;
            else if (r_cnt == CNT_W'(SETTLE_CYCLES - 1))      w_next_state = S_ACCEPT;
         end
         S_ACCEPT:      if (!w_cmd_present) w_next_state = S_VALIDATE;
         S_VALIDATE:    w_next_state = w_go_sensor ? S_SENSOR_REQ : S_LOAD_TX;
         S_SENSOR_REQ:  w_next_state = S_SENSOR_WAIT;
         S_SENSOR_WAIT: if (sensor_done || w_to_expired) w_next_state = S_LOAD_TX;
         S_LOAD_TX:     w_next_state = S_SEND;
         S_SEND:        w_next_state = S_TX_WAIT;
         S_TX_WAIT:     if (r_cnt == CNT_W'(TX_CYCLES - 1)) w_next_state = S_IDLE;
         default:       w_next_state = S_IDLE;
      endcase
   end

   // Output decode.
   always_comb begin
      w_clear = 1'b0;
      w_start = 1'b0;
      w_req   = 1'b0;
      w_busy  = (r_state != S_IDLE);
      case (r_state)
         // Drops in the same cycle commandIn returns to 0xFF.
         S_ACCEPT:     w_clear = w_cmd_present;
         S_SENSOR_REQ: w_req   = 1'b1;
         S_SEND:       w_start = 1'b1;
         default:      ;
      endcase
   end

   assign clearUart   = w_clear;
   assign start_send  = w_start;
   assign sensor_req  = w_req;
   assign busy        = w_busy;
   assign sensor_addr = r_sensor_addr;
   assign address_out = r_address_out;
   assign command_out = r_command_out;
   assign value_out   = r_value_out;

   // Request/response datapath.
   always_ff @(posedge baudClk or posedge reset) begin
      if (reset) begin
         r_addr        <= 8'h00;
         r_cmd         <= 8'h00;
         r_resp_code   <= 8'h00;
         r_resp_val    <= 8'h00;
         r_sensor_addr <= 8'h00;
         r_address_out <= 8'h00;
         r_command_out <= 8'h00;
         r_value_out   <= 8'h00;
      end else begin
         case (r_state)
            S_IDLE: begin
               // Periodic re-read runs as a plain single read of the slot.
               if (w_next_state == S_SENSOR_REQ) begin
                  r_addr        <= w_slot_addr;
                  r_cmd         <= w_slot_humid ? 8'h02 : 8'h01;
                  r_sensor_addr <= w_slot_addr;
               end
            end
            S_SETTLE: begin
               if (w_next_state == S_ACCEPT) begin
                  r_addr <= addressIn;
                  r_cmd  <= commandIn;
               end
            end
            S_VALIDATE: begin
               r_resp_val <= 8'h00;
               if (w_cmd_invalid)       r_resp_code <= RSP_BADCMD;
               else if (w_addr_invalid) r_resp_code <= RSP_BADADR;
               else if (w_cont_off)     r_resp_code <= (r_cmd == 8'h05) ? RSP_TOFF : RSP_HOFF;
               else                     r_sensor_addr <= r_addr;
            end
            S_SENSOR_WAIT: begin
               // Done wins over a timeout expiring in the same cycle.
               if (sensor_done) begin
                  if (sensor_error) begin
                     r_resp_code <= RSP_SERR;
                     r_resp_val  <= 8'h00;
                  end else begin
                     case (r_cmd)
                        8'h00: begin
                           r_resp_code <= RSP_OK;
                           r_resp_val  <= 8'h00;
                        end
                        8'h01, 8'h03: begin
                           r_resp_code <= RSP_TEMP;
                           r_resp_val  <= sensor_temp;
                        end
                        default: begin
                           r_resp_code <= RSP_HUMID;
                           r_resp_val  <= sensor_humid;
                        end
                     endcase
                  end
               end else if (w_to_expired) begin
                  r_resp_code <= RSP_SERR;
                  r_resp_val  <= 8'h00;
               end
            end
            S_LOAD_TX: begin
               r_address_out <= r_addr;
               r_command_out <= r_resp_code;
               r_value_out   <= r_resp_val;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_controller.sv
module tb_uart_controller;

   localparam int SETTLE  = 10;
   localparam int TIMEOUT = 4096;
   localparam int TXC     = 32;
   localparam int PERIOD  = 9600;

   logic       baudClk = 1'b0;
   logic       reset   = 1'b1;
   logic [7:0] addressIn = 8'h00;
   logic [7:0] commandIn = 8'hFF;
   logic       clearUart;
   logic [7:0] address_out, command_out, value_out;
   logic       start_send, sensor_req;
   logic [7:0] sensor_addr;
   logic       sensor_done  = 1'b0;
   logic       sensor_error = 1'b0;
   logic [7:0] sensor_temp  = 8'h00;
   logic [7:0] sensor_humid = 8'h00;
   logic       busy, cont_active;

   always #5 baudClk = ~baudClk;

   uart_controller dut (
      .baudClk(baudClk), .reset(reset),
      .addressIn(addressIn), .commandIn(commandIn), .clearUart(clearUart),
      .address_out(address_out), .command_out(command_out), .value_out(value_out),
      .start_send(start_send), .sensor_req(sensor_req), .sensor_addr(sensor_addr),
      .sensor_done(sensor_done), .sensor_error(sensor_error),
      .sensor_temp(sensor_temp), .sensor_humid(sensor_humid),
      .busy(busy), .cont_active(cont_active)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge baudClk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard queues: expected TX frames and expected sensor addresses.
   logic [23:0] tx_q[$];
   logic [7:0]  sens_q[$];
   logic [23:0] mon_tx;
   logic [7:0]  mon_sa;
   int send_cnt = 0, sreq_cnt = 0, t_send = 0, t_sreq = 0;

   always @(negedge baudClk) begin
      if (start_send) begin
         send_cnt++;
         t_send = cyc;
         if (tx_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_tx: got %02h/%02h/%02h expected no frame",
                     address_out, command_out, value_out);
         end else begin
            mon_tx = tx_q.pop_front();
            check("tx_frame", {8'h00, address_out, command_out, value_out}, {8'h00, mon_tx});
         end
      end
      if (sensor_req) begin
         sreq_cnt++;
         t_sreq = cyc;
         if (sens_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_sensor_req: got addr %02h expected no read", sensor_addr);
         end else begin
            mon_sa = sens_q.pop_front();
            check("sensor_addr", {24'h0, sensor_addr}, {24'h0, mon_sa});
         end
      end
   end

   // Sensor model.
   logic       sens_on    = 1'b1;
   int         sens_delay = 5;
   logic       sens_err   = 1'b0;
   logic [7:0] sens_t     = 8'h00;
   logic [7:0] sens_h     = 8'h00;

   always @(negedge baudClk) begin
      if (sensor_req && sens_on) begin
         repeat (sens_delay) @(negedge baudClk);
         sensor_done  = 1'b1;
         sensor_error = sens_err;
         sensor_temp  = sens_t;
         sensor_humid = sens_h;
         @(negedge baudClk);
         sensor_done  = 1'b0;
      end
   end

   // Acts as the uart receive side: present a pair, wait for clearUart,
   // hold two more cycles, then restore 0xFF.
   task automatic send_req(input logic [7:0] a, input logic [7:0] c);
      int first;
      first = 0;
      @(negedge baudClk);
      addressIn = a;
      commandIn = c;
      for (int n = 1; n <= 200; n++) begin
         @(negedge baudClk);
         if (clearUart) begin
            first = n;
            break;
         end
      end
      if (first == 0) begin
         checks++; errors++;
         $display("FAIL clear_timeout: got no clearUart expected one within 200 cycles");
         commandIn = 8'hFF;
         return;
      end
      check("clear_latency", first, SETTLE + 1);
      repeat (2) @(negedge baudClk);
      check("clear_held", {31'h0, clearUart}, 32'h1);
      commandIn = 8'hFF;
      #1;
      check("clear_drop", {31'h0, clearUart}, 32'h0);
   endtask

   task automatic wait_idle(input int limit, output int when);
      when = -1;
      for (int n = 0; n < limit; n++) begin
         @(negedge baudClk);
         if (!busy) begin
            when = cyc;
            return;
         end
      end
      checks++; errors++;
      $display("FAIL idle_timeout: got busy expected idle within %0d cycles", limit);
   endtask

   task automatic wait_sreq(input int base, input int limit);
      for (int n = 0; n < limit; n++) begin
         @(negedge baudClk);
         if (sreq_cnt != base) return;
      end
      checks++; errors++;
      $display("FAIL sreq_timeout: got no sensor_req expected one within %0d cycles", limit);
   endtask

   int t_idle, base, max_clear, sends0, t1, t2;

   initial begin
      // Reset state.
      #12;
      check("rst_clear",  {31'h0, clearUart},  32'h0);
      check("rst_start",  {31'h0, start_send}, 32'h0);
      check("rst_sreq",   {31'h0, sensor_req}, 32'h0);
      check("rst_busy",   {31'h0, busy},       32'h0);
      check("rst_cont",   {31'h0, cont_active}, 32'h0);
      check("rst_bytes",  {8'h0, address_out, command_out, value_out}, 32'h0);
      check("rst_saddr",  {24'h0, sensor_addr}, 32'h0);
      @(negedge baudClk);
      reset = 1'b0;
      repeat (3) @(negedge baudClk);

      // Temperature read.
      sens_delay = 5; sens_err = 1'b0; sens_t = 8'h19; sens_h = 8'h44;
      base = sreq_cnt;
      sens_q.push_back(8'h03);
      tx_q.push_back(24'h030919);
      send_req(8'h03, 8'h01);
      wait_idle(1000, t_idle);
      check("t1_one_read", sreq_cnt - base, 1);

      // Invalid address, then invalid command: no sensor read.
      base = sreq_cnt;
      tx_q.push_back(24'h40EF00);
      send_req(8'h40, 8'h02);
      wait_idle(1000, t_idle);
      tx_q.push_back(24'h01CF00);
      send_req(8'h01, 8'h0C);
      wait_idle(1000, t_idle);
      check("bad_no_read", sreq_cnt - base, 0);

      // Sensor error.
      sens_err = 1'b1;
      sens_q.push_back(8'h07);
      tx_q.push_back(24'h071F00);
      send_req(8'h07, 8'h01);
      wait_idle(1000, t_idle);
      sens_err = 1'b0;

      // Status with no sensor_done: timeout.
      sens_on = 1'b0;
      sens_q.push_back(8'h00);
      tx_q.push_back(24'h001F00);
      send_req(8'h00, 8'h00);
      wait_idle(6000, t_idle);
      check("timeout_latency", t_send - t_sreq, TIMEOUT + 2);
      check("busy_fall", t_idle - t_send, TXC + 1);
      sens_on = 1'b1;

      // Glitch on commandIn: no latch, no clearUart.
      sends0 = send_cnt;
      max_clear = 0;
      @(negedge baudClk);
      commandIn = 8'hFE;
      repeat (3) begin
         @(negedge baudClk);
         if (clearUart) max_clear = 1;
      end
      commandIn = 8'hFF;
      repeat (20) begin
         @(negedge baudClk);
         if (clearUart) max_clear = 1;
      end
      check("glitch_clear", max_clear, 0);
      check("glitch_idle", {31'h0, busy}, 32'h0);
      check("glitch_no_tx", send_cnt - sends0, 0);

`ifdef UART_CTRL_CONTINUOUS_EN
      // Continuous humidity on addr 2.
      sens_delay = 3; sens_h = 8'h37;
      sens_q.push_back(8'h02);
      tx_q.push_back(24'h020837);
      send_req(8'h02, 8'h04);
      wait_idle(1000, t_idle);
      check("cont_on", {31'h0, cont_active}, 32'h1);
      for (int k = 0; k < 2; k++) begin
         sens_q.push_back(8'h02);
         tx_q.push_back(24'h020837);
         base = sreq_cnt;
         wait_sreq(base, PERIOD + 1000);
         if (k == 0) t1 = t_sreq; else t2 = t_sreq;
         wait_idle(1000, t_idle);
      end
      check("cont_period", {31'h0, (t2 - t1 >= PERIOD) && (t2 - t1 <= PERIOD + 2)}, 32'h1);
      tx_q.push_back(24'h020B00);
      send_req(8'h02, 8'h06);
      wait_idle(1000, t_idle);
      check("cont_off", {31'h0, cont_active}, 32'h0);
      base = sreq_cnt;
      repeat (PERIOD + 400) @(negedge baudClk);
      check("cont_no_reread", sreq_cnt - base, 0);

      // Arm a temperature slot so reset can be seen to clear it.
      sens_t = 8'h21;
      sens_q.push_back(8'h05);
      tx_q.push_back(24'h050921);
      send_req(8'h05, 8'h03);
      wait_idle(1000, t_idle);
      check("cont_temp_on", {31'h0, cont_active}, 32'h1);
`else
      // Without continuous mode: 0x03 is a single read, 0x05 is invalid.
      sens_t = 8'h2A;
      sens_q.push_back(8'h02);
      tx_q.push_back(24'h02092A);
      send_req(8'h02, 8'h03);
      wait_idle(1000, t_idle);
      check("nocont_inactive", {31'h0, cont_active}, 32'h0);
      base = sreq_cnt;
      tx_q.push_back(24'h02CF00);
      send_req(8'h02, 8'h05);
      wait_idle(1000, t_idle);
      repeat (200) @(negedge baudClk);
      check("nocont_no_read", sreq_cnt - base, 0);
`endif

      // Reset pulse during SENSOR_WAIT.
      sens_delay = 50;
      sens_q.push_back(8'h05);
      base = sreq_cnt;
      send_req(8'h05, 8'h01);
      wait_sreq(base, 100);
      repeat (5) @(negedge baudClk);
      check("pre_rst_busy", {31'h0, busy}, 32'h1);
      sends0 = send_cnt;
      #2 reset = 1'b1;
      #1;
      check("arst_busy",  {31'h0, busy}, 32'h0);
      check("arst_saddr", {24'h0, sensor_addr}, 32'h0);
      check("arst_bytes", {8'h0, address_out, command_out, value_out}, 32'h0);
      check("arst_cont",  {31'h0, cont_active}, 32'h0);
      @(negedge baudClk);
      reset = 1'b0;
      repeat (100) @(negedge baudClk);
      check("post_rst_no_tx", send_cnt - sends0, 0);
      check("post_rst_idle", {31'h0, busy}, 32'h0);
      check("post_rst_cont", {31'h0, cont_active}, 32'h0);

      check("tx_q_drained", tx_q.size(), 0);
      check("sens_q_drained", sens_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
